mem_stage_lsu: RTL

- Load/store unit in the MEM stage, directly downstream of the EX/MEM register; consumes ALU_result (address) and reg_read_data2 (store data).
- Drives a word-wide, synchronous-read data memory with byte enables and returns sign/zero-extended load data toward MEM/WB.
- Splits accesses that cross a word boundary into two memory cycles and stalls the pipeline while busy.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_align.sv | 49 ++++
 rtl/mem_stage_lsu.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, funct3 encodings and size/legality helpers for the
// MEM-stage load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        SECOND,
        FINISH
    } lsu_state_t;

    // Access size in bytes; unsigned variants share the size of the signed ones.
    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

    function automatic logic op_legal(input logic ld, input logic st, input logic [2:0] f3);
        if (ld && st) return 1'b0;
        if (ld)       return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        if (st)       return f3 inside {F3_B, F3_H, F3_W};
        return 1'b0;
    endfunction

    // True when the access spills past byte 3 of its word.
    function automatic logic crosses(input logic [1:0] off, input logic [2:0] f3);
        return ({1'b0, off} + size_bytes(f3)) > 3'd4;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for stores (low/high word halves)
// and byte merge plus sign/zero extension for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] lo_word_i,
    input  logic [31:0] rdata_i,
    input  logic        cross_i,
    output logic [3:0]  be_lo_o,
    output logic [3:0]  be_hi_o,
    output logic [31:0] wdata_lo_o,
    output logic [31:0] wdata_hi_o,
    output logic [31:0] load_o
);

    logic [3:0]  mask;
    logic [7:0]  lanes;
    logic [63:0] wsh;
    logic [63:0] rcat;
    logic [31:0] r;

    // Shift a two-word window so the high half naturally holds the spill-over lanes/bytes.
    always_comb begin
        case (size_bytes(funct3_i))
            3'd1:    mask = 4'b0001;
            3'd2:    mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        lanes      = {4'b0000, mask} << off_i;
        be_lo_o    = lanes[3:0];
        be_hi_o    = lanes[7:4];
        wsh        = {32'd0, wdata_i} << {off_i, 3'b000};
        wdata_lo_o = wsh[31:0];
        wdata_hi_o = wsh[63:32];
        rcat       = cross_i ? {rdata_i, lo_word_i} : {32'd0, rdata_i};
        r          = 32'(rcat >> {off_i, 3'b000});
        case (funct3_i)
            F3_B:    load_o = {{24{r[7]}}, r[7:0]};
            F3_H:    load_o = {{16{r[15]}}, r[15:0]};
            F3_BU:   load_o = {24'd0, r[7:0]};
            F3_HU:   load_o = {16'd0, r[15:0]};
            default: load_o = r;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit driving a synchronous-read word
// memory. Word-crossing accesses are split into two memory cycles.
// Build option LSU_MISALIGN_TRAP_EN: crossing accesses fault (misalign_fault)
// instead of being split, with no memory access.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_wen,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              illegal_op,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              misalign_fault,
`endif
    output logic              stall
);

    localparam int WA = ADDR_W - 2;

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q, lo_q, res_q;
    logic              ld_q, st_q, ill_q;
    logic              in_idle, accept, legal, trap, kill;
    logic [1:0]        a_off;
    logic [2:0]        a_f3;
    logic [31:0]       a_wd;
    logic              a_cross;
    logic [3:0]        be_lo, be_hi, be_c;
    logic [31:0]       wd_lo, wd_hi, wd_c, merged;
    logic              wen_c;

    assign in_idle   = (state_q == IDLE);
    assign req_ready = in_idle;
    assign accept    = req_valid && in_idle && (is_load || is_store);
    assign legal     = op_legal(is_load, is_store, funct3);

    // The aligner sees live inputs while issuing the first access, captured ones afterwards.
    assign a_off   = in_idle ? addr[1:0] : addr_q[1:0];
    assign a_f3    = in_idle ? funct3    : f3_q;
    assign a_wd    = in_idle ? wdata     : wdata_q;
    assign a_cross = crosses(a_off, a_f3);

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;
    assign trap           = legal && a_cross;
    assign kill           = ill_q || mis_q;
    assign misalign_fault = done && mis_q;
`else
    assign trap = 1'b0;
    assign kill = ill_q;
`endif

    lsu_align u_align (
        .off_i      (a_off),
        .funct3_i   (a_f3),
        .wdata_i    (a_wd),
        .lo_word_i  (lo_q),
        .rdata_i    (mem_rdata),
        .cross_i    (a_cross),
        .be_lo_o    (be_lo),
        .be_hi_o    (be_hi),
        .wdata_lo_o (wd_lo),
        .wdata_hi_o (wd_hi),
        .load_o     (merged)
    );

    // Next-state and memory-port drive; first access goes out in the accept cycle.
    always_comb begin
        state_d  = state_q;
        mem_addr = addr[ADDR_W-1:2];
        be_c     = 4'b0000;
        wd_c     = 32'd0;
        wen_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (legal && !trap) begin
                        be_c  = be_lo;
                        wd_c  = wd_lo;
                        wen_c = is_store;
                    end
                    state_d = (legal && a_cross && !trap) ? SECOND : FINISH;
                end
            end
            SECOND: begin
                mem_addr = addr_q[ADDR_W-1:2] + {{(WA-1){1'b0}}, 1'b1};
                be_c     = be_hi;
                wd_c     = wd_hi;
                wen_c    = st_q;
                state_d  = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset kills the write strobe combinationally so an in-flight store aborts at once.
    assign mem_wen    = wen_c & reset;
    assign mem_be     = be_c & {4{reset}};
    assign mem_wdata  = wd_c;
    assign done       = (state_q == FINISH);
    assign illegal_op = done && ill_q;
    assign stall      = req_valid && !done;
    // Stores leave the previous load result visible.
    assign load_data  = (done && (ld_q || kill)) ? (kill ? 32'd0 : merged) : res_q;

    // State, request capture, low-word latch for split loads, and result hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            f3_q    <= 3'd0;
            wdata_q <= 32'd0;
            lo_q    <= 32'd0;
            res_q   <= 32'd0;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            ill_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= addr;
                f3_q    <= funct3;
                wdata_q <= wdata;
                ld_q    <= is_load;
                st_q    <= is_store;
                ill_q   <= !legal;
`ifdef LSU_MISALIGN_TRAP_EN
                mis_q   <= trap;
`endif
            end
            if (state_q == SECOND) lo_q <= mem_rdata;
            if (done && (ld_q || kill)) res_q <= load_data;
        end
    end

endmodule
